// File: rtl/stepper_seq_ctrl.sv
// Stepper sequencer: accepts move commands and steps a 4-coil pattern table at a programmable rate.
// Optional STEPPER_IDLE_OFF_EN releases the coils after IDLE_CYC consecutive idle cycles.
module stepper_seq_ctrl #(
    parameter int CNT_W    = 16,
    parameter int DIV_W    = 16,
    parameter int POS_W    = 24,
    parameter int IDLE_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [1:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             stop,
    output logic [3:0]       coil,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] position,
    output logic [CNT_W-1:0] steps_left
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [3:0]         coil_q, coil_d;
    logic               done_q, done_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [CNT_W-1:0]   left_q, left_d;
    logic [DIV_W-1:0]   tick_q, tick_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               dir_q, dir_d;
    logic               half_q, half_d;

`ifdef STEPPER_IDLE_OFF_EN
    localparam int IDLE_W = $clog2(IDLE_CYC + 1);
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
`endif

    function automatic logic [3:0] pattern(input logic [2:0] i);
        case (i)
            3'd0:    pattern = 4'b0001;
            3'd1:    pattern = 4'b0011;
            3'd2:    pattern = 4'b0010;
            3'd3:    pattern = 4'b0110;
            3'd4:    pattern = 4'b0100;
            3'd5:    pattern = 4'b1100;
            3'd6:    pattern = 4'b1000;
            default: pattern = 4'b1001;
        endcase
    endfunction

    // Wave drive sits on even table entries, full drive on odd ones; half uses all eight.
    function automatic logic [2:0] align_idx(input logic [2:0] i, input logic [1:0] mode);
        case (mode)
            2'b00:   align_idx = {i[2:1], 1'b0};
            2'b01:   align_idx = {i[2:1], 1'b1};
            default: align_idx = i;
        endcase
    endfunction

    logic       accept;
    logic [2:0] idx_aligned;
    logic [2:0] step_amt;
    logic [2:0] idx_next;

    assign accept      = cmd_valid && (state_q == S_IDLE);
    assign idx_aligned = align_idx(idx_q, cmd_mode);
    assign step_amt    = half_q ? 3'd1 : 3'd2;
    assign idx_next    = dir_q ? (idx_q + step_amt) : (idx_q - step_amt);

    // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        coil_d  = coil_q;
        done_d  = 1'b0;
        pos_d   = pos_q;
        left_d  = left_q;
        tick_d  = tick_q;
        div_d   = div_q;
        dir_d   = dir_q;
        half_d  = half_q;
`ifdef STEPPER_IDLE_OFF_EN
        idle_cnt_d = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dir_d  = cmd_dir;
                    half_d = cmd_mode[1];
                    div_d  = cmd_div;
                    left_d = cmd_steps;
                    tick_d = '0;
                    if (cmd_steps == '0) begin
                        // An empty move completes at once and leaves the coils untouched.
                        done_d = 1'b1;
                    end else begin
                        idx_d   = idx_aligned;
                        coil_d  = pattern(idx_aligned);
                        state_d = S_RUN;
                    end
                end
`ifdef STEPPER_IDLE_OFF_EN
                else if (coil_q != 4'b0000) begin
                    if (idle_cnt_q == IDLE_W'(IDLE_CYC - 1)) begin
                        coil_d = 4'b0000;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
`endif
            end

            S_RUN: begin
                if (stop) begin
                    // Abort wins over a step falling due in the same cycle.
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    left_d  = '0;
                    tick_d  = '0;
                end else if (tick_q == div_q) begin
                    tick_d = '0;
                    idx_d  = idx_next;
                    coil_d = pattern(idx_next);
                    pos_d  = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
                    left_d = left_q - CNT_W'(1);
                    if (left_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + DIV_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            coil_q  <= '0;
            done_q  <= 1'b0;
            pos_q   <= '0;
            left_q  <= '0;
            tick_q  <= '0;
            div_q   <= '0;
            dir_q   <= 1'b0;
            half_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            coil_q  <= coil_d;
            done_q  <= done_d;
            pos_q   <= pos_d;
            left_q  <= left_d;
            tick_q  <= tick_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
            half_q  <= half_d;
        end
    end

`ifdef STEPPER_IDLE_OFF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q == S_RUN);
    assign done       = done_q;
    assign coil       = coil_q;
    assign position   = pos_q;
    assign steps_left = left_q;

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Directed bench for stepper_seq_ctrl: table of move commands plus hand-written stop, hold,
// zero-step, idle-release and reset-abort sequences.
module tb_stepper_seq_ctrl;

    localparam int CNT_W    = 16;
    localparam int DIV_W    = 16;
    localparam int POS_W    = 24;
    localparam int IDLE_CYC = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [1:0]       cmd_mode;
    logic [CNT_W-1:0] cmd_steps;
    logic [DIV_W-1:0] cmd_div;
    logic             stop;
    logic [3:0]       coil;
    logic             busy;
    logic             done;
    logic [POS_W-1:0] position;
    logic [CNT_W-1:0] steps_left;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stepper_seq_ctrl #(
        .CNT_W    (CNT_W),
        .DIV_W    (DIV_W),
        .POS_W    (POS_W),
        .IDLE_CYC (IDLE_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_mode   (cmd_mode),
        .cmd_steps  (cmd_steps),
        .cmd_div    (cmd_div),
        .stop       (stop),
        .coil       (coil),
        .busy       (busy),
        .done       (done),
        .position   (position),
        .steps_left (steps_left)
    );

    typedef struct {
        logic        dir;
        logic [1:0]  mode;
        logic [15:0] steps;
        logic [15:0] div;
        logic [3:0]  align;
        logic [3:0]  seq [4];
        logic [23:0] end_pos;
    } move_t;

    move_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic dir, input logic [1:0] mode,
                             input logic [15:0] steps, input logic [15:0] div);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_mode  = mode;
        cmd_steps = steps;
        cmd_div   = div;
    endtask

    initial begin
        logic [3:0] prev;

        // Moves run back to back; each starts from the table index the previous one left.
        vecs[0] = '{dir: 1'b1, mode: 2'b10, steps: 16'd4, div: 16'd3, align: 4'b0001,
                    seq: '{4'b0011, 4'b0010, 4'b0110, 4'b0100}, end_pos: 24'd4};
        vecs[1] = '{dir: 1'b0, mode: 2'b01, steps: 16'd3, div: 16'd0, align: 4'b1100,
                    seq: '{4'b0110, 4'b0011, 4'b1001, 4'b0000}, end_pos: 24'd1};
        vecs[2] = '{dir: 1'b1, mode: 2'b00, steps: 16'd3, div: 16'd1, align: 4'b1000,
                    seq: '{4'b0001, 4'b0010, 4'b0100, 4'b0000}, end_pos: 24'd4};
        vecs[3] = '{dir: 1'b0, mode: 2'b11, steps: 16'd2, div: 16'd2, align: 4'b0100,
                    seq: '{4'b0110, 4'b0010, 4'b0000, 4'b0000}, end_pos: 24'd2};
        vecs[4] = '{dir: 1'b0, mode: 2'b00, steps: 16'd4, div: 16'd0, align: 4'b0010,
                    seq: '{4'b0001, 4'b1000, 4'b0100, 4'b0010}, end_pos: 24'hFFFFFE};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_mode  = 2'b00;
        cmd_steps = '0;
        cmd_div   = '0;
        stop      = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        repeat (10) cyc();
        check("rst_coil", 32'(coil), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_pos", 32'(position), 32'h0);
        check("rst_left", 32'(steps_left), 32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h1);

        for (int i = 0; i < 5; i++) begin
            drive_cmd(vecs[i].dir, vecs[i].mode, vecs[i].steps, vecs[i].div);
            cyc();
            cmd_valid = 1'b0;
            check($sformatf("v%0d_align", i), 32'(coil), 32'(vecs[i].align));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
            check($sformatf("v%0d_ready", i), 32'(cmd_ready), 32'h0);
            check($sformatf("v%0d_left", i), 32'(steps_left), 32'(vecs[i].steps));
            for (int k = 0; k < int'(vecs[i].steps); k++) begin
                prev = (k == 0) ? vecs[i].align : vecs[i].seq[k-1];
                repeat (int'(vecs[i].div)) cyc();
                if (vecs[i].div != 16'd0)
                    check($sformatf("v%0d_early%0d", i, k), 32'(coil), 32'(prev));
                cyc();
                check($sformatf("v%0d_coil%0d", i, k), 32'(coil), 32'(vecs[i].seq[k]));
                check($sformatf("v%0d_left%0d", i, k), 32'(steps_left),
                      32'(int'(vecs[i].steps) - 1 - k));
                check($sformatf("v%0d_done%0d", i, k), 32'(done),
                      32'(k == int'(vecs[i].steps) - 1));
                check($sformatf("v%0d_busy%0d", i, k), 32'(busy),
                      32'(k != int'(vecs[i].steps) - 1));
            end
            check($sformatf("v%0d_pos", i), 32'(position), 32'(vecs[i].end_pos));
            cyc();
            check($sformatf("v%0d_done_drop", i), 32'(done), 32'h0);
        end

        // Zero-step command: done next cycle, nothing else moves.
        drive_cmd(1'b1, 2'b10, 16'd0, 16'd5);
        cyc();
        cmd_valid = 1'b0;
        check("zero_done", 32'(done), 32'h1);
        check("zero_busy", 32'(busy), 32'h0);
        check("zero_coil", 32'(coil), 32'h2);
        check("zero_pos", 32'(position), 32'h00FFFFFE);
        check("zero_ready", 32'(cmd_ready), 32'h1);
        cyc();
        check("zero_done_drop", 32'(done), 32'h0);
        check("zero_coil_hold", 32'(coil), 32'h2);

        // Long move aborted by stop; a different command stays on the bus throughout RUN.
        drive_cmd(1'b1, 2'b10, 16'd100, 16'd9);
        cyc();
        cmd_steps = 16'd1;
        cmd_div   = 16'd0;
        check("stop_busy", 32'(busy), 32'h1);
        check("stop_ready", 32'(cmd_ready), 32'h0);
        repeat (20) cyc();
        check("stop_left20", 32'(steps_left), 32'd98);
        check("stop_pos20", 32'(position), 32'h0);
        check("stop_ready20", 32'(cmd_ready), 32'h0);
        repeat (14) cyc();
        stop = 1'b1;
        cyc();
        check("stop_busy_end", 32'(busy), 32'h0);
        check("stop_done", 32'(done), 32'h1);
        check("stop_left_end", 32'(steps_left), 32'h0);
        check("stop_pos_end", 32'(position), 32'h1);
        check("stop_coil_end", 32'(coil), 32'b1100);
        check("stop_ready_end", 32'(cmd_ready), 32'h1);
        cyc();
        stop      = 1'b0;
        cmd_valid = 1'b0;
        check("held_busy", 32'(busy), 32'h1);
        check("held_left", 32'(steps_left), 32'h1);
        check("held_coil", 32'(coil), 32'b1100);
        check("held_done", 32'(done), 32'h0);
        cyc();
        check("held_step_coil", 32'(coil), 32'b1000);
        check("held_step_done", 32'(done), 32'h1);
        check("held_step_busy", 32'(busy), 32'h0);
        check("held_step_pos", 32'(position), 32'h2);

`ifdef STEPPER_IDLE_OFF_EN
        repeat (IDLE_CYC - 1) cyc();
        check("idle_before_off", 32'(coil), 32'b1000);
        cyc();
        check("idle_off", 32'(coil), 32'h0);
`else
        repeat (1000) cyc();
        check("idle_hold", 32'(coil), 32'b1000);
`endif

        // Reset in the middle of a move aborts without a done pulse.
        drive_cmd(1'b1, 2'b01, 16'd10, 16'd0);
        cyc();
        cmd_valid = 1'b0;
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        check("rrun_done", 32'(done), 32'h0);
        check("rrun_busy", 32'(busy), 32'h0);
        check("rrun_coil", 32'(coil), 32'h0);
        check("rrun_pos", 32'(position), 32'h0);
        check("rrun_left", 32'(steps_left), 32'h0);
        rst = 1'b0;
        cyc();
        check("rrun_done_after", 32'(done), 32'h0);
        check("rrun_ready_after", 32'(cmd_ready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
